// File: rtl/systolic_mm_param.sv
// Output-stationary N x N systolic matrix multiplier: C = A x B, or C += A x B.
// Whole operand matrices in, skewed into a MAC mesh, result matrix out over valid/ready.
module systolic_mm_param #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*N*DATA_W-1:0]   mat_a,
  input  logic [N*N*DATA_W-1:0]   mat_b,
  input  logic                    signed_mode,
  input  logic                    accumulate,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*N*ACC_W-1:0]    mat_c,
  output logic                    busy
);

  localparam int LAST_STEP = 3*N - 3;
  localparam int STEP_W    = $clog2(3*N - 2) + 1;
  localparam int PROD_W    = 2*DATA_W;
  localparam int PAD_W     = ACC_W - PROD_W;

  if (ACC_W < 2*DATA_W + $clog2(N)) begin : g_acc_w_check
    $error("systolic_mm_param: ACC_W too small for N and DATA_W");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [STEP_W-1:0]   step_reg;
  logic                mode_signed_reg;
  logic [DATA_W-1:0]   a_mat_reg  [N][N];
  logic [DATA_W-1:0]   b_mat_reg  [N][N];
  logic [DATA_W-1:0]   a_pipe_reg [N][N];
  logic [DATA_W-1:0]   b_pipe_reg [N][N];
  logic [ACC_W-1:0]    acc_reg    [N][N];

  logic [DATA_W-1:0]   feed_a [N];
  logic [DATA_W-1:0]   feed_b [N];
  logic [DATA_W-1:0]   a_in   [N][N];
  logic [DATA_W-1:0]   b_in   [N][N];
  logic [PROD_W-1:0]   prod_s [N][N];
  logic [PROD_W-1:0]   prod_u [N][N];
  logic [ACC_W-1:0]    prod   [N][N];

  logic accept;

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = RUN;
      RUN:  if (step_reg == STEP_W'(LAST_STEP)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Skewed feeders: row r presents A[r][k] at step r+k, column c presents B[k][c] at step c+k.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      feed_a[r] = '0;
      feed_b[r] = '0;
      for (int k = 0; k < N; k++) begin
        if (int'(step_reg) == r + k) begin
          feed_a[r] = a_mat_reg[r][k];
          feed_b[r] = b_mat_reg[k][r];
        end
      end
    end
  end

  // Products use sign- or zero-extended operands; the low 2*DATA_W bits are exact either way.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) a_in[i][j] = feed_a[i];
        else        a_in[i][j] = a_pipe_reg[i][j-1];
        if (i == 0) b_in[i][j] = feed_b[j];
        else        b_in[i][j] = b_pipe_reg[i-1][j];
        prod_s[i][j] = {{DATA_W{a_in[i][j][DATA_W-1]}}, a_in[i][j]}
                     * {{DATA_W{b_in[i][j][DATA_W-1]}}, b_in[i][j]};
        prod_u[i][j] = {{DATA_W{1'b0}}, a_in[i][j]} * {{DATA_W{1'b0}}, b_in[i][j]};
        if (mode_signed_reg) prod[i][j] = {{PAD_W{prod_s[i][j][PROD_W-1]}}, prod_s[i][j]};
        else                 prod[i][j] = {{PAD_W{1'b0}}, prod_u[i][j]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_reg        <= '0;
      mode_signed_reg <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_mat_reg[i][j]  <= '0;
          b_mat_reg[i][j]  <= '0;
          a_pipe_reg[i][j] <= '0;
          b_pipe_reg[i][j] <= '0;
          acc_reg[i][j]    <= '0;
        end
      end
    end else if (accept) begin
      step_reg        <= '0;
      mode_signed_reg <= signed_mode;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_mat_reg[i][j]  <= mat_a[(N*N-1-(i*N+j))*DATA_W +: DATA_W];
          b_mat_reg[i][j]  <= mat_b[(N*N-1-(i*N+j))*DATA_W +: DATA_W];
          a_pipe_reg[i][j] <= '0;
          b_pipe_reg[i][j] <= '0;
          if (!accumulate) acc_reg[i][j] <= '0;
        end
      end
    end else if (state_reg == RUN) begin
      step_reg <= step_reg + 1'b1;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_reg[i][j]    <= acc_reg[i][j] + prod[i][j];
          a_pipe_reg[i][j] <= a_in[i][j];
          b_pipe_reg[i][j] <= b_in[i][j];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign mat_c[(N*N-1-(gi*N+gj))*ACC_W +: ACC_W] = acc_reg[gi][gj];
    end
  end

endmodule
